uart_alu_ctrl: RTL

Frame sequencer between the UART receive/transmit FIFOs and the combinational ALU. It pops a three-byte frame from the RX FIFO in the order operand A, operand B, opcode, and holds the captured operands on the ALU inputs. It then registers the ALU result and pushes it into the TX FIFO once space is available. An inter-byte timeout discards stalled partial frames, and a wrapping counter records completed operations.

---
 rtl/uart_alu_ctrl_if.sv | 38 +++
 rtl/uart_alu_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl_if.sv
// rtl/uart_alu_ctrl_if.sv - FIFO, ALU and status bundle for the UART ALU frame sequencer
//
// Groups every signal between the sequencer and its surroundings.
//   master : sequencer side (pops RX, pushes TX, drives ALU operands and status)
//   slave  : environment side (RX/TX FIFOs and the combinational ALU)
// Signals:
//   rx_data/rx_empty/rx_rd         RX FIFO head (first-word-fall-through), empty flag, pop
//   tx_full/tx_wr/tx_data          TX FIFO full flag, push, registered result
//   alu_a/alu_b/alu_op/alu_result  registered operands and opcode, ALU output
//   busy/frame_err/op_count        status: not idle, timeout abort pulse, completed frames
interface uart_alu_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_empty;
    logic              rx_rd;
    logic              tx_full;
    logic              tx_wr;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              frame_err;
    logic [15:0]       op_count;

    modport master (
        input  rx_data, rx_empty, tx_full, alu_result,
        output rx_rd, tx_wr, tx_data, alu_a, alu_b, alu_op, busy, frame_err, op_count
    );

    modport slave (
        output rx_data, rx_empty, tx_full, alu_result,
        input  rx_rd, tx_wr, tx_data, alu_a, alu_b, alu_op, busy, frame_err, op_count
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - three-byte frame sequencer between UART FIFOs and a combinational ALU
//
// Pops operand A, operand B and the opcode from the RX FIFO, holds them on the
// ALU inputs, registers the ALU result and pushes it to the TX FIFO when space
// is available. A stalled partial frame is dropped after TIMEOUT consecutive
// empty cycles while waiting for B or the opcode.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    uart_alu_ctrl_if master modport (FIFO, ALU and status signals)
module uart_alu_ctrl #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    uart_alu_ctrl_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [15:0]       op_count_q;
    logic              frame_err_q;

    logic in_rx_state;
    logic in_wait_state;
    logic tmo_hit;

    assign in_rx_state   = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_OP);
    // Only a partially received frame can time out; GET_A idles forever.
    assign in_wait_state = (state_q == GET_B) || (state_q == GET_OP);
    // A byte present on the limit cycle is popped instead of aborting.
    assign tmo_hit       = in_wait_state && bus.rx_empty && (tmo_cnt_q == LIMIT);

    // Pop and push are Mealy on the FIFO flags so a waiting byte or free TX
    // slot is used in the same cycle; reset masks them combinationally.
    assign bus.rx_rd     = !reset && in_rx_state && !bus.rx_empty;
    assign bus.tx_wr     = !reset && (state_q == SEND) && !bus.tx_full;

    assign bus.busy      = (state_q != GET_A);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.op_count  = op_count_q;
    assign bus.frame_err = frame_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= GET_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tx_data_q   <= '0;
            tmo_cnt_q   <= '0;
            op_count_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                GET_A: begin
                    if (!bus.rx_empty) begin
                        alu_a_q   <= bus.rx_data;
                        tmo_cnt_q <= '0;
                        state_q   <= GET_B;
                    end
                end
                GET_B: begin
                    if (!bus.rx_empty) begin
                        alu_b_q   <= bus.rx_data;
                        tmo_cnt_q <= '0;
                        state_q   <= GET_OP;
                    end else if (tmo_hit) begin
                        frame_err_q <= 1'b1;
                        tmo_cnt_q   <= '0;
                        state_q     <= GET_A;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                GET_OP: begin
                    if (!bus.rx_empty) begin
                        alu_op_q  <= bus.rx_data[OP_W-1:0];
                        tmo_cnt_q <= '0;
                        state_q   <= EXEC;
                    end else if (tmo_hit) begin
                        frame_err_q <= 1'b1;
                        tmo_cnt_q   <= '0;
                        state_q     <= GET_A;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle; take the result.
                    tx_data_q <= bus.alu_result;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (!bus.tx_full) begin
                        op_count_q <= op_count_q + 16'd1;
                        tmo_cnt_q  <= '0;
                        state_q    <= GET_A;
                    end
                end
                default: begin
                    tmo_cnt_q <= '0;
                    state_q   <= GET_A;
                end
            endcase
        end
    end
endmodule
